// File: rtl/muldiv_pkg.sv
// muldiv_pkg: operation codes, FSM states and iteration count shared by the multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_e;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
  localparam int ITERS = 32;
endpackage

// File: rtl/muldiv_unit_div_core.sv
// div_core: radix-2 restoring divider on operand magnitudes with final sign fix.
module div_core #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_load,
  input  logic         i_step,
  input  logic         i_signed,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_quot,
  output logic [W-1:0] o_rem,
  output logic         o_zero
);
  logic [W-1:0] r_q, r_r, r_d;
  logic         r_neg_q, r_neg_r, r_zero;
  logic [W:0]   w_sh, w_diff;
  assign w_sh   = {r_r, r_q[W-1]};
  assign w_diff = w_sh - {1'b0, r_d};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q     <= '0;
      r_r     <= '0;
      r_d     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_zero  <= 1'b0;
    end else if (i_load) begin
      r_q     <= (i_signed && i_a[W-1]) ? -i_a : i_a;
      r_d     <= (i_signed && i_b[W-1]) ? -i_b : i_b;
      r_r     <= '0;
      r_neg_q <= i_signed && (i_a[W-1] ^ i_b[W-1]);
      r_neg_r <= i_signed && i_a[W-1];
      r_zero  <= i_b == '0;
    end else if (i_step) begin
      r_r <= w_diff[W] ? w_sh[W-1:0] : w_diff[W-1:0];
      r_q <= {r_q[W-2:0], ~w_diff[W]};
    end
  end
  // With a zero divisor the remainder register ends up holding |a|, so the sign fix restores a.
  assign o_quot = r_zero ? '1 : (r_neg_q ? -r_q : r_q);
  assign o_rem  = r_neg_r ? -r_r : r_r;
  assign o_zero = r_zero;
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply/divide unit with iterative shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [2:0]            md_op,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;
  localparam logic [4:0] LAST = 5'(ITERS - 1);
`ifdef MULDIV_FAST_MUL_EN
  localparam state_e MUL_ENTRY = S_FIX;
`else
  localparam state_e MUL_ENTRY = S_MUL;
`endif
  state_e         r_state, w_next;
  logic [4:0]     r_cnt;
  logic           r_neg, r_is_div, r_done, r_dz;
  logic [W-1:0]   r_hi, r_lo, r_mplier;
  logic [2*W-1:0] r_prod, r_mcand;
  logic           w_accept, w_is_mul, w_is_div, w_sgn, w_mul_neg, w_zero;
  logic [W-1:0]   w_a_mag, w_b_mag, w_quot, w_rem;
  logic [2*W-1:0] w_prod_init, w_prod_fin;
  assign w_accept = start && (r_state == S_IDLE);
  assign w_is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign w_is_div = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign w_sgn    = (md_op == OP_MULT) || (md_op == OP_DIV);
  assign w_a_mag  = (w_sgn && a_in[W-1]) ? -a_in : a_in;
  assign w_b_mag  = (w_sgn && b_in[W-1]) ? -b_in : b_in;
`ifdef MULDIV_FAST_MUL_EN
  // Sign-extended operands give the correct signed or unsigned product in the low 2W bits.
  assign w_prod_init = {{W{w_sgn && a_in[W-1]}}, a_in} * {{W{w_sgn && b_in[W-1]}}, b_in};
  assign w_mul_neg   = 1'b0;
`else
  assign w_prod_init = '0;
  assign w_mul_neg   = w_sgn && (a_in[W-1] ^ b_in[W-1]);
`endif
  assign w_prod_fin = r_neg ? -r_prod : r_prod;
  assign busy       = r_state != S_IDLE;
  assign done       = r_done;
  assign div_zero   = r_dz;
  assign hi         = r_hi;
  assign lo         = r_lo;
  div_core #(.W(W)) u_div (
    .clk      (clk),
    .resetn   (resetn),
    .i_load   (w_accept && w_is_div),
    .i_step   (r_state == S_DIV),
    .i_signed (w_sgn),
    .i_a      (a_in),
    .i_b      (b_in),
    .o_quot   (w_quot),
    .o_rem    (w_rem),
    .o_zero   (w_zero)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = !w_accept ? S_IDLE : w_is_mul ? MUL_ENTRY : w_is_div ? S_DIV : S_IDLE;
      S_MUL, S_DIV: w_next = (r_cnt == LAST) ? S_FIX : r_state;
      S_FIX:        w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
    end else begin
      r_done <= r_state == S_FIX;
      r_cnt  <= (r_state == S_MUL || r_state == S_DIV) ? r_cnt + 5'd1 : '0;
      if (w_accept && (w_is_mul || w_is_div)) begin
        r_dz     <= 1'b0;
        r_is_div <= w_is_div;
        r_neg    <= w_mul_neg;
        r_mcand  <= {{W{1'b0}}, w_a_mag};
        r_mplier <= w_b_mag;
        r_prod   <= w_prod_init;
      end
      if (w_accept && md_op == OP_MTHI) r_hi <= a_in;
      if (w_accept && md_op == OP_MTLO) r_lo <= a_in;
      if (r_state == S_MUL) begin
        if (r_mplier[0]) r_prod <= r_prod + r_mcand;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (r_state == S_FIX) begin
        {r_hi, r_lo} <= r_is_div ? {w_rem, w_quot} : w_prod_fin;
        if (r_is_div) r_dz <= w_zero;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table vectors, hand-written corner sequences and random ops against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam logic [2:0] BUSY_OP = (MUL_LAT == 1) ? 3'd2 : 3'd0;
  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .md_op    (md_op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );
  always #5 clk = ~clk;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic        m_dz = 1'b0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    logic        edz;
  } vec_t;
  vec_t vt[12];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic int exp_lat(input logic [2:0] op);
    return (op < 3'd2) ? MUL_LAT : (op < 3'd4) ? 33 : 0;
  endfunction
  function automatic void ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic dz);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    h = m_hi;
    l = m_lo;
    dz = m_dz;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb); {h, l} = p; dz = 1'b0; end
      3'd1: begin {h, l} = {32'd0, a} * {32'd0, b}; dz = 1'b0; end
      3'd2, 3'd3: begin
        dz = (b == 0);
        if (b == 0) begin h = a; l = 32'hFFFFFFFF; end
        else if (op == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 0; l = a; end
        else if (op == 3'd2) begin l = sa / sb; h = sa % sb; end
        else begin l = a / b; h = a % b; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; md_op = op; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0; md_op = 3'($urandom); a_in = $urandom; b_in = $urandom;
  endtask
  task automatic finish_op(input int n0, input int lat, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz, input string nm);
    int n = n0;
    bit hold = 1'b1;
    while (busy && n < 40) begin
      if (hi !== m_hi || lo !== m_lo || done !== 1'b0) hold = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(lat));
    if (lat > 0) chk({nm, " hold"}, 64'(hold), 64'd1);
    chk({nm, " done"}, 64'(done), 64'(lat > 0));
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
    chk({nm, " div_zero"}, 64'(div_zero), 64'(edz));
    @(posedge clk); #1;
    chk({nm, " done drop"}, 64'(done), 64'd0);
    m_hi = eh; m_lo = el; m_dz = edz;
  endtask
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz, input string nm);
    issue(op, a, b);
    finish_op(0, exp_lat(op), eh, el, edz, nm);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] eh, el, a, b;
    logic        edz;
    logic [2:0]  op;
    int          dn;
    vt[0]  = '{3'd0, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 1'b0};
    vt[2]  = '{3'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3]  = '{3'd3, 32'h7,        32'h2,        32'h1,        32'h3,        1'b0};
    vt[4]  = '{3'd2, 32'h5,        32'h0,        32'h5,        32'hFFFFFFFF, 1'b1};
    vt[5]  = '{3'd1, 32'h3,        32'h3,        32'h0,        32'h9,        1'b0};
    vt[6]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
    vt[7]  = '{3'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h0,        32'h6,        1'b0};
    vt[8]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0};
    vt[9]  = '{3'd3, 32'h80000000, 32'h0,        32'h80000000, 32'hFFFFFFFF, 1'b1};
    vt[10] = '{3'd6, 32'h1111,     32'h2222,     32'h80000000, 32'hFFFFFFFF, 1'b1};
    vt[11] = '{3'd2, 32'd100,      32'hFFFFFFF9, 32'h2,        32'hFFFFFFF2, 1'b0};
    #2 resetn = 1'b0;
    #10;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 12; i++)
      do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].edz, $sformatf("vec%0d", i));
    // mthi then mtlo on back-to-back edges
    @(negedge clk);
    start = 1'b1; md_op = 3'd4; a_in = 32'h12345678;
    @(posedge clk); #1;
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi hi", 64'(hi), 64'h12345678);
    md_op = 3'd5; a_in = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mtlo done", 64'(done), 64'd0);
    chk("mtlo hi", 64'(hi), 64'h12345678);
    chk("mtlo lo", 64'(lo), 64'h9ABCDEF0);
    m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
    // start while busy must be ignored
    ref_md(BUSY_OP, 32'h00012345, 32'h0000ABCD, eh, el, edz);
    issue(BUSY_OP, 32'h00012345, 32'h0000ABCD);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; md_op = 3'd3; a_in = 32'd100; b_in = 32'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("ignored busy", 64'(busy), 64'd1);
    finish_op(5, exp_lat(BUSY_OP), eh, el, edz, "ignored");
    // reset in the middle of a divide
    issue(3'd2, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk) resetn = 1'b1;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || busy || hi != 0 || lo != 0) dn++;
    end
    chk("midreset quiet", 64'(dn), 64'd0);
    // start on the first edge after reset release
    #2 resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1; start = 1'b1; md_op = 3'd1; a_in = 32'd3; b_in = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    finish_op(0, MUL_LAT, 32'd0, 32'd15, 1'b0, "post-reset");
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9)) ^ {32{b[31]}};
      ref_md(op, a, b, eh, el, edz);
      do_op(op, a, b, eh, el, edz, $sformatf("rnd%0d op%0d", i, op));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
